// File: rtl/ne_pkg.sv
// ne_pkg: shared constants for the nonlinear-energy (NE) chain.
//   NE_IN_W     : width of the signed per-sample NE value
//   NE_LOG2_WIN : log2 of the sliding-window length
//   NE_SKIP     : upstream priming samples discarded after reset
//   NE_ACC_W    : width of the signed window sum (cannot overflow)
package ne_pkg;

    localparam int unsigned NE_IN_W     = 64;
    localparam int unsigned NE_LOG2_WIN = 4;
    localparam int unsigned NE_SKIP     = 2;
    localparam int unsigned NE_ACC_W    = NE_IN_W + NE_LOG2_WIN;

endpackage : ne_pkg

// File: rtl/ne_sample_ring.sv
// ne_sample_ring: WINDOW-deep ring of the most recent accepted NE samples.
//   clk, rst  : clock, synchronous active-high reset (clears the pointer only)
//   wr_en     : store wr_data at the write pointer and advance it
//   wr_data   : sample to store
//   oldest_c  : combinational read at the write pointer, i.e. the sample
//               about to be overwritten (valid once the ring is full)
module ne_sample_ring
    import ne_pkg::*;
#(
    parameter int unsigned IN_W     = NE_IN_W,
    parameter int unsigned LOG2_WIN = NE_LOG2_WIN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic signed [IN_W-1:0] wr_data,
    output logic signed [IN_W-1:0] oldest_c
);

    localparam int unsigned WINDOW = 1 << LOG2_WIN;

    logic signed [IN_W-1:0] ring_q [WINDOW];
    logic [LOG2_WIN-1:0]    wr_ptr_q;

    // Write pointer wraps naturally at WINDOW.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
        end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + LOG2_WIN'(1);
        end
    end

    // Storage carries no reset; contents are only read once the ring is full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ring_q[wr_ptr_q] <= wr_data;
        end
    end

    // Read-before-write: the oldest sample is visible in the cycle it is replaced.
    assign oldest_c = ring_q[wr_ptr_q];

endmodule : ne_sample_ring

// File: rtl/ne_window_accum.sv
// ne_window_accum: sliding-window sum of the NE sample stream with
// threshold detect. Drops the first SKIP valid samples after reset.
//   clk, rst   : clock, synchronous active-high reset
//   din        : signed NE sample
//   din_valid  : sample qualifier
//   thresh     : signed detect threshold, used in the accept cycle
//   dout_sum   : signed window sum (registered, updated on every accept)
//   dout_valid : one-cycle pulse when an accept leaves the window full
//   detect     : registered dout_sum > thresh (strict, signed)
//   fill       : samples currently held in the window, 0..WINDOW
module ne_window_accum
    import ne_pkg::*;
#(
    parameter int unsigned IN_W     = NE_IN_W,
    parameter int unsigned LOG2_WIN = NE_LOG2_WIN,
    parameter int unsigned SKIP     = NE_SKIP,
    parameter int unsigned ACC_W    = IN_W + LOG2_WIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  din,
    input  logic                    din_valid,
    input  logic signed [ACC_W-1:0] thresh,
    output logic signed [ACC_W-1:0] dout_sum,
    output logic                    dout_valid,
    output logic                    detect,
    output logic [LOG2_WIN:0]       fill
);

    localparam int unsigned WINDOW = 1 << LOG2_WIN;
    localparam int unsigned SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [LOG2_WIN:0]  FILL_FULL = (LOG2_WIN + 1)'(WINDOW);
    localparam logic [SKIP_W-1:0]  SKIP_END  = SKIP_W'(SKIP);

    logic [SKIP_W-1:0]       skip_q;
    logic                    skip_done_c;
    logic                    drop_c;
    logic                    accept_c;
    logic                    win_full_c;
    logic signed [IN_W-1:0]  oldest_c;
    logic signed [ACC_W-1:0] din_ext_c;
    logic signed [ACC_W-1:0] old_ext_c;
    logic signed [ACC_W-1:0] sum_next_c;
    logic [LOG2_WIN:0]       fill_next_c;

    ne_sample_ring #(
        .IN_W     (IN_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept_c),
        .wr_data  (din),
        .oldest_c (oldest_c)
    );

    // Sample classification: warm-up drop versus accept.
    always_comb begin
        skip_done_c = (skip_q == SKIP_END);
        drop_c      = din_valid && !skip_done_c && !rst;
        accept_c    = din_valid &&  skip_done_c && !rst;
    end

    // Window update; dout_sum doubles as the running sum.
    always_comb begin
        win_full_c  = (fill == FILL_FULL);
        din_ext_c   = ACC_W'(din);
        old_ext_c   = win_full_c ? ACC_W'(oldest_c) : '0;
        sum_next_c  = dout_sum + din_ext_c - old_ext_c;
        fill_next_c = win_full_c ? fill : fill + (LOG2_WIN + 1)'(1);
    end

    // Skip counter, fill counter, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q     <= '0;
            fill       <= '0;
            dout_sum   <= '0;
            dout_valid <= 1'b0;
            detect     <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (drop_c) begin
                skip_q <= skip_q + SKIP_W'(1);
            end
            if (accept_c) begin
                dout_sum   <= sum_next_c;
                detect     <= (sum_next_c > thresh);
                fill       <= fill_next_c;
                dout_valid <= (fill_next_c == FILL_FULL);
            end
        end
    end

endmodule : ne_window_accum

// File: tb/tb_ne_window_accum.sv
// Self-checking bench for ne_window_accum (IN_W=64, WINDOW=4, SKIP=2).
module tb_ne_window_accum;

    localparam int unsigned IN_W     = 64;
    localparam int unsigned LOG2_WIN = 2;
    localparam int unsigned SKIP     = 2;
    localparam int unsigned ACC_W    = IN_W + LOG2_WIN;
    localparam int          WINDOW   = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic signed [IN_W-1:0]  din = '0;
    logic                    din_valid = 1'b0;
    logic signed [ACC_W-1:0] thresh = '0;
    logic signed [ACC_W-1:0] dout_sum;
    logic                    dout_valid;
    logic                    detect;
    logic [LOG2_WIN:0]       fill;

    ne_window_accum #(
        .IN_W     (IN_W),
        .LOG2_WIN (LOG2_WIN),
        .SKIP     (SKIP),
        .ACC_W    (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .thresh     (thresh),
        .dout_sum   (dout_sum),
        .dout_valid (dout_valid),
        .detect     (detect),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic signed [ACC_W:0] got,
                       input logic signed [ACC_W:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: keeps the last WINDOW accepted samples and sums them.
    logic signed [IN_W-1:0]  mq[$];
    int                      mskip = 0;
    logic signed [ACC_W-1:0] exp_sum = '0;
    logic                    exp_valid = 1'b0;
    logic                    exp_det = 1'b0;
    int                      exp_fill = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mskip     = 0;
            exp_sum   = '0;
            exp_valid = 1'b0;
            exp_det   = 1'b0;
            exp_fill  = 0;
        end else if (din_valid) begin
            if (mskip < SKIP) begin
                mskip++;
                exp_valid = 1'b0;
            end else begin
                logic signed [ACC_W-1:0] s;
                mq.push_back(din);
                if (mq.size() > WINDOW) void'(mq.pop_front());
                s = '0;
                foreach (mq[i]) s = s + ACC_W'(mq[i]);
                exp_sum   = s;
                exp_det   = (s > thresh);
                exp_fill  = mq.size();
                exp_valid = (mq.size() == WINDOW);
            end
        end else begin
            exp_valid = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("sum",    dout_sum,   exp_sum);
            chk("valid",  dout_valid, exp_valid);
            chk("detect", detect,     exp_det);
            chk("fill",   fill,       (ACC_W + 1)'(exp_fill));
        end
    end

    task automatic step(input logic r, input logic v, input logic signed [IN_W-1:0] x,
                        input logic signed [ACC_W-1:0] th);
        rst = r; din_valid = v; din = x; thresh = th;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, IN_W'({$urandom, $urandom}), '0);
    endtask

    int lit_sum[5] = '{18, 22, 26, 30, 34};
    int pm_sum[4]  = '{-10, 0, 10, 20};
    bit pm_det[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};

    logic signed [IN_W-1:0]  in_min;
    logic signed [IN_W-1:0]  in_max;
    logic signed [ACC_W-1:0] lit_min;
    logic signed [ACC_W-1:0] lit_max;

    initial begin
        in_min  = {1'b1, 63'b0};
        in_max  = {1'b0, {63{1'b1}}};
        lit_min = {1'b1, 65'b0};
        lit_max = {1'b0, {63{1'b1}}, 2'b00};

        // Reset with din_valid high: reset must win.
        step(1'b1, 1'b1, 64'sd77, '0);
        started = 1'b1;
        chk("rst_sum",   dout_sum,   0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_det",   detect,     0);
        chk("rst_fill",  fill,       0);

        // Consecutive stream 1..10, thresh 21.
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, IN_W'(k), 66'sd21);
            if (k >= 3) chk("lit_fill", fill, (k - 2 > 4) ? 4 : k - 2);
            if (k <= 5) chk("lit_novalid", dout_valid, 0);
            if (k >= 6) begin
                chk("lit_sum",   dout_sum,   lit_sum[k-6]);
                chk("lit_valid", dout_valid, 1);
                chk("lit_det",   detect,     (k >= 7) ? 1 : 0);
            end
        end
        // Window 7,8,9,10 -> replace 7 with -5 gives 22; equality is not a detect.
        step(1'b0, 1'b1, -64'sd5, 66'sd22);
        chk("eq_sum", dout_sum, 22);
        chk("eq_det", detect,   0);
        idle(2);
        chk("hold_sum", dout_sum,   22);
        chk("hold_vld", dout_valid, 0);

        // Same stream with random gaps.
        step(1'b1, 1'b0, '0, '0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, IN_W'(k), 66'sd21);
            if (k >= 6) chk("gap_sum", dout_sum, lit_sum[k-6]);
            idle((k == 1) ? 2 : int'($urandom_range(3)));
        end

        // Constant -5 then +5, thresh 0.
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 64'sd99, '0);
        step(1'b0, 1'b1, 64'sd99, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, -64'sd5, '0);
        chk("neg_sum", dout_sum, -20);
        chk("neg_det", detect,   0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 64'sd5, '0);
            chk("pm_sum", dout_sum, pm_sum[i]);
            chk("pm_det", detect,   pm_det[i]);
        end

        // Reset after 3 accepted samples; warm-up re-arms.
        step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, IN_W'(i + 1), '0);
        step(1'b1, 1'b1, 64'sd50, '0);
        chk("mid_sum",  dout_sum, 0);
        chk("mid_fill", fill,     0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, IN_W'(10 * (i + 1)), '0);
        chk("mid_res", dout_sum, 30 + 40 + 50 + 60);

        // Extremes: no wrap in the 66-bit sum.
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, in_min, '0);
        chk("min_sum", dout_sum, lit_min);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, in_max, '0);
        chk("max_sum", dout_sum, lit_max);
        chk("max_det", detect,   1);

        // Random: small values (frequent threshold ties), then full range.
        for (int n = 0; n < 3000; n++) begin
            logic r;
            logic v;
            r = ($urandom_range(150) == 0);
            v = ($urandom_range(3) != 0);
            if (n < 1500)
                step(r, v, IN_W'(int'($urandom_range(16)) - 8),
                     ACC_W'(int'($urandom_range(40)) - 20));
            else
                step(r, v, IN_W'({$urandom, $urandom}),
                     ACC_W'(signed'({$urandom, $urandom, $urandom})));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ne_window_accum
